scan_select_seq: RTL and testbench



---
 rtl/scan_select_seq_pkg.sv | 46 ++++
 rtl/scan_select_seq_if.sv | 18 +
 rtl/scan_dwell_ctr.sv | 28 ++
 rtl/scan_select_seq.sv | 139 +++++++++++++
 tb/tb_scan_select_seq.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/scan_select_seq_pkg.sv
// Shared definitions for the decoder scan sequencer.
//   state_t     : FSM state encoding (IDLE/ACTIVE/BLANK)
//   next_t      : result of the next-channel search (found, wrap, idx)
//   next_chan() : round-robin search for the next unmasked channel
//   first_chan(): lowest unmasked channel, used when starting from IDLE
package scan_select_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_BLANK  = 2'd2
    } state_t;

    typedef struct packed {
        logic       found;
        logic       wrap;
        logic [1:0] idx;
    } next_t;

    // Scan idx+1 .. idx+4 (mod 4). The last candidate is idx itself, so a
    // single unmasked channel is reselected. wrap flags a new idx <= old idx.
    function automatic next_t next_chan(input logic [1:0] idx, input logic [3:0] mask);
        next_t      r;
        logic [1:0] c;
        r = '0;
        for (int k = 1; k <= 4; k++) begin
            c = idx + 2'(k);
            if (!r.found && !mask[c]) begin
                r.found = 1'b1;
                r.idx   = c;
                r.wrap  = (c <= idx);
            end
        end
        return r;
    endfunction

    function automatic logic [1:0] first_chan(input logic [3:0] mask);
        logic [1:0] r;
        r = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (!mask[k]) r = 2'(k);
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_select_seq_if.sv
// Bus between a scan controller and the sequencer.
//   en, dwell, skip_mask        : control from master
//   A, B, E, busy, sweep_done   : registered outputs from the sequencer
interface scan_select_seq_if #(parameter int DWELL_W = 8);
    logic               en;
    logic [DWELL_W-1:0] dwell;
    logic [3:0]         skip_mask;
    logic               A;
    logic               B;
    logic               E;
    logic               busy;
    logic               sweep_done;

    modport master (output en, dwell, skip_mask,
                    input  A, B, E, busy, sweep_done);
    modport slave  (input  en, dwell, skip_mask,
                    output A, B, E, busy, sweep_done);
endinterface

// File: rtl/scan_dwell_ctr.sv
// Loadable down-counter with terminal-count flag.
//   clk, rst : clock, async active-high reset (count -> 0)
//   load     : load load_val (has priority over dec)
//   dec      : decrement, saturating at 0
//   tc       : count == 1, i.e. the last cycle of the interval
module scan_dwell_ctr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         tc
);
    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != '0)
            count <= count - W'(1);
    end

    assign tc = (count == W'(1));
endmodule

// File: rtl/scan_select_seq.sv
// Round-robin select/enable sequencer for a 2-to-4 decoder.
//   clk, rst : clock, async active-high reset
//   bus      : en/dwell/skip_mask in; A/B (index MSB/LSB), E, busy,
//              sweep_done out -- all outputs registered
// Each channel holds E high for max(dwell,1) cycles, then E low for
// BLANK_CYC cycles. The index moves on the edge that drops E, so the
// decoder never sees A/B change while enabled (unless BLANK_CYC is 0).
module scan_select_seq
    import scan_select_seq_pkg::*;
#(
    parameter int DWELL_W   = 8,
    parameter int BLANK_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    scan_select_seq_if.slave  bus
);
    localparam int BW = $clog2(BLANK_CYC + 1);
    localparam int CW = (DWELL_W > BW) ? DWELL_W : BW;

    state_t     state;
    logic [1:0] idx;
    logic       e_q, busy_q, sd_q;

    next_t      nxt;
    logic [1:0] first;
    logic       any_chan;
    logic       dwell_load, blank_load, dwell_tc, blank_tc;
    logic [CW-1:0] dwell_val;

    assign nxt       = next_chan(idx, bus.skip_mask);
    assign first     = first_chan(bus.skip_mask);
    assign any_chan  = ~&bus.skip_mask;
    assign dwell_val = (bus.dwell == '0) ? CW'(1) : CW'(bus.dwell);

    // Counter loads coincide with the FSM transitions into ACTIVE/BLANK.
    always_comb begin
        dwell_load = 1'b0;
        blank_load = 1'b0;
        if (bus.en) begin
            case (state)
                ST_IDLE:   dwell_load = any_chan;
                ST_ACTIVE: if (dwell_tc && nxt.found) begin
                    if (BLANK_CYC == 0) dwell_load = 1'b1;
                    else                blank_load = 1'b1;
                end
                ST_BLANK:  dwell_load = blank_tc;
                default:   ;
            endcase
        end
    end

    scan_dwell_ctr #(.W(CW)) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (dwell_load),
        .dec      (state == ST_ACTIVE),
        .load_val (dwell_val),
        .tc       (dwell_tc)
    );

    scan_dwell_ctr #(.W(CW)) u_blank (
        .clk      (clk),
        .rst      (rst),
        .load     (blank_load),
        .dec      (state == ST_BLANK),
        .load_val (CW'(BLANK_CYC)),
        .tc       (blank_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= 2'd0;
            e_q    <= 1'b0;
            busy_q <= 1'b0;
            sd_q   <= 1'b0;
        end else begin
            sd_q <= 1'b0;
            if (!bus.en) begin
                // Abandon whatever channel is in progress.
                state  <= ST_IDLE;
                idx    <= 2'd0;
                e_q    <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (any_chan) begin
                            // Starting a sweep is not a wrap: no sweep_done.
                            state  <= ST_ACTIVE;
                            idx    <= first;
                            e_q    <= 1'b1;
                            busy_q <= 1'b1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (dwell_tc) begin
                            if (!nxt.found) begin
                                // Every channel masked at advance time.
                                state  <= ST_IDLE;
                                idx    <= 2'd0;
                                e_q    <= 1'b0;
                                busy_q <= 1'b0;
                            end else begin
                                idx  <= nxt.idx;
                                sd_q <= nxt.wrap;
                                if (BLANK_CYC == 0) begin
                                    state <= ST_ACTIVE;
                                end else begin
                                    state <= ST_BLANK;
                                    e_q   <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_BLANK: begin
                        if (blank_tc) begin
                            state <= ST_ACTIVE;
                            e_q   <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        idx    <= 2'd0;
                        e_q    <= 1'b0;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.A          = idx[1];
    assign bus.B          = idx[0];
    assign bus.E          = e_q;
    assign bus.busy       = busy_q;
    assign bus.sweep_done = sd_q;
endmodule

// File: tb/tb_scan_select_seq.sv
// Scoreboard bench: two sequencers (BLANK_CYC=2 and BLANK_CYC=0) share one
// stimulus stream. Each cycle the stimulus process advances a position-in-
// period reference model and queues the expected outputs; a monitor pops
// and compares just after every rising edge.
module tb_scan_select_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] dwell = 8'd0;
    logic [3:0] mask = 4'd0;

    always #5 clk = ~clk;

    scan_select_seq_if #(.DWELL_W(8)) bus0 ();
    scan_select_seq_if #(.DWELL_W(8)) bus1 ();

    assign bus0.en = en;  assign bus0.dwell = dwell;  assign bus0.skip_mask = mask;
    assign bus1.en = en;  assign bus1.dwell = dwell;  assign bus1.skip_mask = mask;

    scan_select_seq #(.DWELL_W(8), .BLANK_CYC(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    scan_select_seq #(.DWELL_W(8), .BLANK_CYC(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Model: run flag, current channel, position within the channel period
    // (0..d-1 enabled, d..d+blank-1 blanked), latched dwell d, wrap pulse.
    typedef struct {
        bit       run;
        bit [1:0] ch;
        int       pos;
        int       d;
        bit       sd;
    } mdl_t;

    typedef struct packed {
        logic [1:0] ab;
        logic       e;
        logic       busy;
        logic       sd;
    } obs_t;

    mdl_t m0, m1;
    obs_t q0[$], q1[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    function automatic mdl_t mreset();
        mdl_t n;
        n.run = 0; n.ch = 0; n.pos = 0; n.d = 1; n.sd = 0;
        return n;
    endfunction

    function automatic mdl_t mstep(mdl_t s, int blank, bit en_i, int dw, bit [3:0] mk);
        mdl_t     n;
        bit [1:0] c;
        bit       hit;
        int       dmax;
        n = s;
        n.sd = 0;
        dmax = (dw == 0) ? 1 : dw;
        if (!en_i) begin
            n.run = 0; n.ch = 0; n.pos = 0;
        end else if (!s.run) begin
            if (mk != 4'hF) begin
                n.run = 1; n.pos = 0; n.d = dmax;
                for (int k = 3; k >= 0; k--) if (!mk[k]) n.ch = 2'(k);
            end
        end else begin
            n.pos = s.pos + 1;
            if (n.pos == s.d) begin
                hit = 0;
                for (int k = 1; k <= 4; k++) begin
                    c = 2'((s.ch + k) % 4);
                    if (!hit && !mk[c]) begin hit = 1; n.ch = c; end
                end
                if (!hit) begin
                    n.run = 0; n.ch = 0; n.pos = 0;
                end else begin
                    n.sd = (n.ch <= s.ch);
                    if (blank == 0) begin n.pos = 0; n.d = dmax; end
                end
            end else if (n.pos == s.d + blank) begin
                n.pos = 0; n.d = dmax;
            end
        end
        return n;
    endfunction

    function automatic obs_t mexp(mdl_t s);
        obs_t o;
        o.ab   = s.ch;
        o.e    = s.run && (s.pos < s.d);
        o.busy = s.run;
        o.sd   = s.sd;
        return o;
    endfunction

    task automatic check(string nm, obs_t got, obs_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got ab=%b E=%b busy=%b sd=%b, expected ab=%b E=%b busy=%b sd=%b",
                     nm, cyc, got.ab, got.e, got.busy, got.sd, exp.ab, exp.e, exp.busy, exp.sd);
        end
    endtask

    function automatic obs_t sample0();
        obs_t o;
        o = {bus0.A, bus0.B, bus0.E, bus0.busy, bus0.sweep_done};
        return o;
    endfunction

    function automatic obs_t sample1();
        obs_t o;
        o = {bus1.A, bus1.B, bus1.E, bus1.busy, bus1.sweep_done};
        return o;
    endfunction

    // Drive one cycle of inputs and queue the outputs due after the next edge.
    task automatic cycle(bit r, bit e_i, int dw, bit [3:0] mk);
        @(negedge clk);
        rst = r; en = e_i; dwell = 8'(dw); mask = mk;
        if (r) begin
            m0 = mreset(); m1 = mreset();
        end else begin
            m0 = mstep(m0, 2, e_i, dw, mk);
            m1 = mstep(m1, 0, e_i, dw, mk);
        end
        q0.push_back(mexp(m0));
        q1.push_back(mexp(m1));
        cyc++;
    endtask

    // Reset asserted between edges must clear outputs before the next edge.
    task automatic async_rst();
        obs_t z;
        z = '0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst0", sample0(), z);
        check("async_rst1", sample1(), z);
        m0 = mreset(); m1 = mreset();
        q0.push_back(z);
        q1.push_back(z);
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) check("dut0", sample0(), q0.pop_front());
            if (q1.size() > 0) check("dut1", sample1(), q1.pop_front());
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit       e_r;
        int       dw_r;
        bit [3:0] mk_r;
        int       wait_n;
        m0 = mreset(); m1 = mreset();

        repeat (3) cycle(1, 0, 0, 4'h0);                // reset state
        repeat (20) cycle(0, 1, 3, 4'h0);               // dwell 3, full sweep
        repeat (16) cycle(0, 1, 2, 4'b0101);            // channels 1,3 only
        repeat (10) cycle(0, 1, 0, 4'h0);               // dwell 0 -> 1 cycle
        cycle(0, 0, 0, 4'h0);
        repeat (8) cycle(0, 1, 3, 4'hF);                // all masked: stay idle
        repeat (12) cycle(0, 1, 1, 4'h0);               // back-to-back (dut1)
        repeat (6) cycle(0, 1, 4, 4'b0111);             // single channel 3
        repeat (6) cycle(0, 1, 4, 4'hF);                // mask all while running

        // Drop en while dut0 is enabled on channel 2.
        cycle(0, 0, 3, 4'h0);
        wait_n = 0;
        while (!(m0.run && m0.ch == 2'd2 && m0.pos < m0.d) && wait_n < 40) begin
            cycle(0, 1, 3, 4'h0);
            wait_n++;
        end
        tests++;
        if (wait_n >= 40) begin
            fails++;
            $display("FAIL reach_ch2: channel 2 not reached within %0d cycles", wait_n);
        end
        cycle(0, 0, 3, 4'h0);
        repeat (2) cycle(0, 1, 3, 4'h0);

        repeat (7) cycle(0, 1, 2, 4'h0);
        async_rst();
        cycle(0, 1, 2, 4'h0);
        repeat (10) cycle(0, 1, 2, 4'h0);

        e_r = 1; dw_r = 2; mk_r = 4'h0;
        for (int i = 0; i < 3000; i++) begin
            e_r = ($urandom_range(0, 40) != 0);
            if ($urandom_range(0, 19) == 0) dw_r = $urandom_range(0, 5);
            if ($urandom_range(0, 24) == 0) mk_r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 499) == 0) async_rst();
            cycle(0, e_r, dw_r, mk_r);
        end

        repeat (3) cycle(0, 0, 0, 4'h0);
        @(posedge clk);
        #2;
        tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d/%0d entries left, expected 0", q0.size(), q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
